// File: rtl/shift_frame_ctrl.sv
// Sequences WIDTH shift_en pulses into a serial-in shift register and captures the result.
// Latency: start-to-word_valid is WIDTH*(cfg_div+1)+2 clk cycles.
// Backpressure: a finished word that finds an unconsumed word pending is dropped and flags overrun.
module shift_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] sr_data,
  output logic             shift_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_shift;
  logic               w_capture;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   r_div_lat;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_word_data;
  logic               r_word_valid;
  logic               r_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and shift strobe; abort suppresses the strobe in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_div_cnt == '0) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(WIDTH-1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit-rate divider and pulse counter; the divider is latched once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_div_lat <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div_cnt <= cfg_div;
            r_div_lat <= cfg_div;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_bit_cnt <= '0;
          end else if (w_shift) begin
            r_div_cnt <= r_div_lat;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end else begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture succeeds if the output slot is free or being emptied at this very edge.
  assign w_capture = (r_state == S_DONE) && (!r_word_valid || word_ready);

  // Output word slot and sticky overrun; a dropped word wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_word_data  <= sr_data;
        r_word_valid <= 1'b1;
      end else if (word_ready) begin
        r_word_valid <= 1'b0;
      end
      if ((r_state == S_DONE) && !w_capture) r_overrun <= 1'b1;
      else if (clr_overrun)                  r_overrun <= 1'b0;
    end
  end

  assign shift_en   = w_shift;
  assign busy       = (r_state != S_IDLE);
  assign bit_cnt    = r_bit_cnt;
  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl with a behavioural right-shifting serial-in register.
// Inputs change on the falling edge; outputs are checked 1ns later in the same cycle.
// The serial bit fed on pulse i is pat[i], so a full frame leaves sr == pat.
module tb_shift_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [7:0] sr_data;
  logic       shift_en;
  logic [7:0] word_data;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       busy;
  logic [3:0] bit_cnt;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  logic [7:0] pat = 8'h00;
  logic [7:0] sr = 8'h00;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.WIDTH(8), .DIV_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_div(cfg_div),
    .sr_data(sr_data), .shift_en(shift_en), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Serial-in right-shifting register under control of shift_en.
  always_ff @(posedge clk) begin
    if (shift_en) sr <= {pat[bit_cnt[2:0]], sr[7:1]};
  end
  assign sr_data = sr;

  // Start one frame; word_ready is driven to rdy only in the DONE cycle. Returns in the first valid cycle.
  task automatic run_frame(input logic [7:0] p, input logic [7:0] div, input logic rdy);
    int lat;
    lat = 8 * (int'(div) + 1) + 2;
    pat = p;
    cfg_div = div;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      start = (c == 0);
      word_ready = (c == lat - 1) ? rdy : 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (shift_en !== 1'b0) begin n_bad++; $display("FAIL reset_shift_en got %b exp 0", shift_en); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    n_cmp++; if (word_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h exp 00", word_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_bit_cnt got %0d exp 0", bit_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pat = 8'h4D;
    cfg_div = 8'd0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      n_cmp++; if (shift_en !== (c >= 1 && c <= 8)) begin n_bad++; $display("FAIL basic_shift_en c=%0d got %b", c, shift_en); end
      n_cmp++; if (busy !== (c >= 1 && c <= 9)) begin n_bad++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
      n_cmp++; if (word_valid !== (c >= 10)) begin n_bad++; $display("FAIL basic_valid c=%0d got %b", c, word_valid); end
    end
    n_cmp++; if (word_data !== 8'h4D) begin n_bad++; $display("FAIL basic_data got %h exp 4d", word_data); end
    n_cmp++; if (bit_cnt !== 4'd8) begin n_bad++; $display("FAIL basic_bit_cnt got %0d exp 8", bit_cnt); end
    @(negedge clk); word_ready = 1'b1;
    @(negedge clk); word_ready = 1'b0; #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume got %b exp 0", word_valid); end
    n_cmp++; if (bit_cnt !== 4'd8) begin n_bad++; $display("FAIL basic_bit_cnt_hold got %0d exp 8", bit_cnt); end
  endtask

  task automatic test_div();
    pat = 8'hA7;
    cfg_div = 8'd3;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 5) cfg_div = 8'd0;
      #1;
      n_cmp++; if (shift_en !== (c >= 4 && c <= 32 && (c % 4) == 0)) begin n_bad++; $display("FAIL div_shift_en c=%0d got %b", c, shift_en); end
      n_cmp++; if (word_valid !== (c >= 34)) begin n_bad++; $display("FAIL div_valid c=%0d got %b", c, word_valid); end
    end
    n_cmp++; if (word_data !== 8'hA7) begin n_bad++; $display("FAIL div_data got %h exp a7", word_data); end
    @(negedge clk); word_ready = 1'b1;
    @(negedge clk); word_ready = 1'b0;
  endtask

  task automatic test_overrun();
    run_frame(8'h3C, 8'd0, 1'b0);
    n_cmp++; if (word_data !== 8'h3C) begin n_bad++; $display("FAIL ovr_first_data got %h exp 3c", word_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first_flag got %b exp 0", overrun); end
    run_frame(8'h81, 8'd0, 1'b0);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b exp 1", word_valid); end
    n_cmp++; if (word_data !== 8'h3C) begin n_bad++; $display("FAIL ovr_kept_data got %h exp 3c", word_data); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b exp 1", overrun); end
    @(negedge clk); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0; #1;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    run_frame(8'h5A, 8'd0, 1'b1);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_replace_valid got %b exp 1", word_valid); end
    n_cmp++; if (word_data !== 8'h5A) begin n_bad++; $display("FAIL ovr_replace_data got %h exp 5a", word_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_replace_flag got %b exp 0", overrun); end
    @(negedge clk); word_ready = 1'b1;
    @(negedge clk); word_ready = 1'b0; #1;
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drain got %b exp 0", word_valid); end
  endtask

  task automatic test_abort();
    pat = 8'hFF;
    cfg_div = 8'd0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = (c == 0);
      abort = (c == 4);
      #1;
      if (c == 3) begin
        n_cmp++; if (bit_cnt !== 4'd2) begin n_bad++; $display("FAIL abort_cnt3 got %0d exp 2", bit_cnt); end
      end
      if (c == 4) begin
        n_cmp++; if (shift_en !== 1'b0) begin n_bad++; $display("FAIL abort_shift_en got %b exp 0", shift_en); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_same got %b exp 1", busy); end
        n_cmp++; if (bit_cnt !== 4'd3) begin n_bad++; $display("FAIL abort_cnt4 got %0d exp 3", bit_cnt); end
      end
    end
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_next got %b exp 0", busy); end
    n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL abort_cnt_clr got %0d exp 0", bit_cnt); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b exp 0", word_valid); end
    run_frame(8'hC3, 8'd0, 1'b0);
    n_cmp++; if (word_data !== 8'hC3) begin n_bad++; $display("FAIL abort_next_data got %h exp c3", word_data); end
    n_cmp++; if (bit_cnt !== 4'd8) begin n_bad++; $display("FAIL abort_next_cnt got %0d exp 8", bit_cnt); end
    @(negedge clk); word_ready = 1'b1;
    @(negedge clk); word_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pat = 8'h96;
    cfg_div = 8'd1;
    for (int c = 0; c <= 56; c++) begin
      @(negedge clk);
      start = (c < 54);
      word_ready = 1'b1;
      #1;
      n_cmp++; if (word_valid !== (c >= 18 && (c % 18) == 0)) begin n_bad++; $display("FAIL b2b_valid c=%0d got %b", c, word_valid); end
      n_cmp++; if (busy !== (c < 54 && (c % 18) != 0)) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b", c, busy); end
      if (word_valid === 1'b1) begin
        n_cmp++; if (word_data !== 8'h96) begin n_bad++; $display("FAIL b2b_data c=%0d got %h exp 96", c, word_data); end
      end
    end
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 5 || c == 7);
      #1;
      n_cmp++; if (word_valid !== (c == 18)) begin n_bad++; $display("FAIL pulse_valid c=%0d got %b", c, word_valid); end
      n_cmp++; if (busy !== (c >= 1 && c <= 17)) begin n_bad++; $display("FAIL pulse_busy c=%0d got %b", c, busy); end
    end
    word_ready = 1'b0;
  endtask

  task automatic test_rst();
    run_frame(8'hE1, 8'd0, 1'b0);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got %b exp 1", word_valid); end
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 5);
      rst = (c == 4 || c == 5);
      #1;
    end
    rst = 1'b0;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", word_valid); end
    n_cmp++; if (word_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h exp 00", word_data); end
    n_cmp++; if (bit_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_bit_cnt got %0d exp 0", bit_cnt); end
    n_cmp++; if (shift_en !== 1'b0) begin n_bad++; $display("FAIL rst_shift_en got %b exp 0", shift_en); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b exp 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
